// File: rtl/seq_hit_logger.sv
// seq_hit_logger
//   Counts hits from a 1010 overlapping Mealy detector and logs a timestamp
//   for each hit into a small show-ahead FIFO drained by a host.
//
//   Ports:
//     clk        : single clock, all state updates on the rising edge
//     rst        : asynchronous active-high reset
//     z          : detector output, 1 = hit this cycle
//     clr        : synchronous clear of all state (highest priority)
//     rd_en      : pop head entry, honoured only while rd_valid = 1
//     rd_data    : head-of-FIFO timestamp, 0 when empty (no read latency)
//     rd_valid   : FIFO non-empty
//     fifo_level : number of stored entries
//     hit_count  : hits sampled since reset/clear, dropped hits included
//     overflow   : sticky, set when a hit is dropped on a full FIFO
//
//   Build option: define HIT_COUNT_SATURATE_EN to make hit_count saturate at
//   its maximum instead of wrapping to zero.
module seq_hit_logger #(
   parameter int TS_W  = 16,
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     z,
   input  logic                     clr,
   input  logic                     rd_en,
   output logic [TS_W-1:0]          rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         hit_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [TS_W-1:0]  ts_reg;
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [CNT_W-1:0] hit_count_reg;
   logic [CNT_W-1:0] hit_count_next;
   logic             overflow_reg;

   logic [TS_W-1:0]  mem [DEPTH];

   logic             empty;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   // Pointers carry one extra wrap bit: equal means empty, equal except for
   // the wrap bit means full.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // A pop in the same cycle frees a slot, so a hit on a full FIFO still
   // lands when the host is reading.
   assign pop  = !clr && rd_en && !empty;
   assign push = !clr && z && (!full || pop);
   assign drop = !clr && z && full && !pop;

`ifdef HIT_COUNT_SATURATE_EN
   assign hit_count_next = (hit_count_reg == {CNT_W{1'b1}}) ? hit_count_reg
                                                            : hit_count_reg + CNT_ONE;
`else
   assign hit_count_next = hit_count_reg + CNT_ONE;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_reg        <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         hit_count_reg <= '0;
         overflow_reg  <= 1'b0;
      end else if (clr) begin
         ts_reg        <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         hit_count_reg <= '0;
         overflow_reg  <= 1'b0;
      end else begin
         ts_reg <= ts_reg + TS_ONE;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (z) begin
            hit_count_reg <= hit_count_next;
         end
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Storage needs no reset: every read is gated by the pointer state.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= ts_reg;
      end
   end

   assign rd_valid   = !empty;
   assign rd_data    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
   assign fifo_level = wr_ptr_reg - rd_ptr_reg;
   assign hit_count  = hit_count_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_seq_hit_logger.sv
// Testbench for seq_hit_logger: directed scenarios plus randomized traffic.
// A reference model (queue of timestamps, integer counters) predicts state;
// expected timestamps go into a scoreboard queue that a separate monitor
// drains whenever the DUT presents a valid head that is being read.
module tb_seq_hit_logger;

   localparam int TS_W  = 16;
   localparam int CNT_W = 8;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   z;
   logic                   clr;
   logic                   rd_en;
   logic [TS_W-1:0]        rd_data;
   logic                   rd_valid;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [CNT_W-1:0]       hit_count;
   logic                   overflow;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int model_q[$];
   int exp_q[$];
   int m_ts;
   int m_hits;
   bit m_ovf;

   seq_hit_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .z          (z),
      .clr        (clr),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .fifo_level (fifo_level),
      .hit_count  (hit_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      model_q.delete();
      exp_q.delete();
      m_ts   = 0;
      m_hits = 0;
      m_ovf  = 1'b0;
   endtask

   // One clock edge of the reference behaviour, from the rules alone.
   task automatic model_step(input bit zi, input bit ci, input bit ri);
      if (ci) begin
         model_clear();
      end else begin
         if (ri && model_q.size() > 0) void'(model_q.pop_front());
         if (zi) begin
`ifdef HIT_COUNT_SATURATE_EN
            m_hits = (m_hits == 255) ? 255 : m_hits + 1;
`else
            m_hits = (m_hits + 1) % 256;
`endif
            if (model_q.size() < DEPTH) begin
               model_q.push_back(m_ts);
               exp_q.push_back(m_ts);
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_ts = (m_ts + 1) % 65536;
      end
   endtask

   // Called at posedge+1; drives inputs for the next edge and returns at
   // the following posedge+1.
   task automatic cycle(input bit zi, input bit ci, input bit ri);
      z = zi; clr = ci; rd_en = ri;
      @(posedge clk);
      model_step(zi, ci, ri);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      z = 1'b0; clr = 1'b0; rd_en = 1'b0;
      rst = 1'b1;
      model_clear();
      #1;
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_hit_count", int'(hit_count), 0);
      chk("rst_overflow", int'(overflow), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compares DUT state with the model mid-cycle and pops the
   // scoreboard whenever the head is consumed at the coming edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("mon_rd_valid", int'(rd_valid), int'(model_q.size() != 0));
            chk("mon_level", int'(fifo_level), model_q.size());
            chk("mon_hit_count", int'(hit_count), m_hits);
            chk("mon_overflow", int'(overflow), int'(m_ovf));
            if (exp_q.size() > 0) chk("mon_rd_data", int'(rd_data), exp_q[0]);
            else                  chk("mon_rd_data_empty", int'(rd_data), 0);
            if (rd_valid && rd_en && !clr) begin
               if (exp_q.size() == 0) chk("sb_underflow", int'(rd_data), -1);
               else void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; z = 1'b0; clr = 1'b0; rd_en = 1'b0;
      do_reset();

      // reset mid-run with 2 entries stored, then first hit at ts=3
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      chk("pre_rst_level", int'(fifo_level), 2);
      do_reset();
      idle(3);
      cycle(1'b1, 1'b0, 1'b0);
      chk("post_rst_rd_data", int'(rd_data), 3);

      // single hit at ts=5
      cycle(1'b0, 1'b1, 1'b0);
      idle(5);
      cycle(1'b1, 1'b0, 1'b0);
      chk("single_rd_valid", int'(rd_valid), 1);
      chk("single_rd_data", int'(rd_data), 5);
      chk("single_level", int'(fifo_level), 1);
      chk("single_hit_count", int'(hit_count), 1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("single_pop_valid", int'(rd_valid), 0);
      chk("single_pop_level", int'(fifo_level), 0);

      // overflow: hits at ts 10,12,14,16,18
      cycle(1'b0, 1'b1, 1'b0);
      idle(10);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (i < 4) cycle(1'b0, 1'b0, 1'b0);
      end
      chk("ovf_level", int'(fifo_level), 4);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_hit_count", int'(hit_count), 5);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain_data", int'(rd_data), 10 + 2 * i);
         cycle(1'b0, 1'b0, 1'b1);
      end
      chk("ovf_drain_empty", int'(rd_valid), 0);

      // full with simultaneous push and pop
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1);
      chk("fullpp_level", int'(fifo_level), 4);
      chk("fullpp_overflow", int'(overflow), 0);
      chk("fullpp_head", int'(rd_data), 1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
      chk("fullpp_tail", int'(rd_data), 4);
      cycle(1'b0, 1'b0, 1'b1);

      // counter boundary: 256 hits with continuous reads
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 256; i++) cycle(1'b1, 1'b0, 1'b1);
`ifdef HIT_COUNT_SATURATE_EN
      chk("cnt_boundary", int'(hit_count), 255);
`else
      chk("cnt_boundary", int'(hit_count), 0);
`endif
      chk("cnt_overflow", int'(overflow), 0);

      // clear priority with 3 entries stored
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      chk("clr_level", int'(fifo_level), 0);
      chk("clr_hit_count", int'(hit_count), 0);
      chk("clr_overflow", int'(overflow), 0);
      cycle(1'b1, 1'b0, 1'b0);
      chk("clr_ts_zero", int'(rd_data), 0);

      // randomized traffic with varying read pressure
      for (int i = 0; i < 1600; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            cycle(bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 79) == 0),
                  bit'($urandom_range(0, 3) < ((i / 200) % 4)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
